// File: rtl/membus_arbiter.sv
// membus_arbiter
// Two-requester arbiter in front of a single-outstanding membus downstream.
// A grant latches the winner's request into a local buffer (IDLE), the buffer
// is presented downstream until accepted (ISSUE), then the block waits for the
// single response and routes it back to the owner (WAIT).
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   m0_* / m1_*              requester request channel (valid/ready, addr,
//                            wen, wdata, wmask) and response (rvalid, rdata)
//   s_*                      downstream request channel and response
//   busy                     a transaction is in flight (state != IDLE)
//   owner                    requester of the current or last transaction
//
// Parameter ROUND_ROBIN: 1 = alternate on contention, 0 = m0 always wins.
module membus_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic        m0_wen,
    input  logic [63:0] m0_wdata,
    input  logic [7:0]  m0_wmask,
    output logic        m0_rvalid,
    output logic [63:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic        m1_wen,
    input  logic [63:0] m1_wdata,
    input  logic [7:0]  m1_wmask,
    output logic        m1_rvalid,
    output logic [63:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic        s_wen,
    output logic [63:0] s_wdata,
    output logic [7:0]  s_wmask,
    input  logic        s_rvalid,
    input  logic [63:0] s_rdata,

    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic RR_EN = 1'(ROUND_ROBIN != 0);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;

    logic        grant_m1_s;
    logic        m0_ready_s, m1_ready_s;
    logic        m0_rvalid_s, m1_rvalid_s;
    logic        s_valid_s;

    // Arbitration: a lone requester always wins; on contention round-robin
    // picks the one that did not win last time, fixed priority picks m0.
    always_comb begin
        grant_m1_s = m1_valid && (!m0_valid || (RR_EN && !last_grant_q));
    end

    // Next-state, request buffer and handshake outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        m0_ready_s   = 1'b0;
        m1_ready_s   = 1'b0;
        m0_rvalid_s  = 1'b0;
        m1_rvalid_s  = 1'b0;
        s_valid_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    owner_d      = grant_m1_s;
                    last_grant_d = grant_m1_s;
                    state_d      = ST_ISSUE;
                    if (grant_m1_s) begin
                        m1_ready_s = 1'b1;
                        addr_d     = m1_addr;
                        wen_d      = m1_wen;
                        wdata_d    = m1_wdata;
                        wmask_d    = m1_wmask;
                    end else begin
                        m0_ready_s = 1'b1;
                        addr_d     = m0_addr;
                        wen_d      = m0_wen;
                        wdata_d    = m0_wdata;
                        wmask_d    = m0_wmask;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Any s_rvalid here is ignored: the downstream cannot answer
                // in the cycle it accepts the request.
                s_valid_s = 1'b1;
                if (s_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (s_rvalid) begin
                    if (owner_q) begin
                        m1_rvalid_s = 1'b1;
                    end else begin
                        m0_rvalid_s = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= 32'h0;
            wen_q        <= 1'b0;
            wdata_q      <= 64'h0;
            wmask_q      <= 8'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

    // Handshake strobes are held low during reset so an in-flight transaction
    // is abandoned without a grant, issue or response leaking out.
    assign m0_ready  = m0_ready_s  & ~rst;
    assign m1_ready  = m1_ready_s  & ~rst;
    assign m0_rvalid = m0_rvalid_s & ~rst;
    assign m1_rvalid = m1_rvalid_s & ~rst;
    assign s_valid   = s_valid_s   & ~rst;
    assign busy      = (state_q != ST_IDLE) & ~rst;

    assign owner     = owner_q;
    assign s_addr    = addr_q;
    assign s_wen     = wen_q;
    assign s_wdata   = wdata_q;
    assign s_wmask   = wmask_q;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: a round-robin and a fixed-priority instance share
// all inputs (their timing is identical, only the winner differs). The driver
// plays both requesters and the downstream, and pushes expected grants,
// downstream requests and responses into queues; the monitor pops and compares.
module tb_membus_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    logic clk = 1'b1;
    logic rst = 1'b1;

    logic        m0_valid, m0_wen, m1_valid, m1_wen;
    logic [31:0] m0_addr, m1_addr;
    logic [63:0] m0_wdata, m1_wdata;
    logic [7:0]  m0_wmask, m1_wmask;
    logic        s_ready, s_rvalid;
    logic [63:0] s_rdata;

    // index 0 = round-robin instance, index 1 = fixed-priority instance
    logic [1:0]  m0_ready_w, m1_ready_w, m0_rvalid_w, m1_rvalid_w;
    logic [1:0]  s_valid_w, s_wen_w, busy_w, owner_w;
    logic [63:0] m0_rdata_w [2];
    logic [63:0] m1_rdata_w [2];
    logic [63:0] s_wdata_w [2];
    logic [31:0] s_addr_w [2];
    logic [7:0]  s_wmask_w [2];

    membus_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready_w[0]), .m0_addr(m0_addr), .m0_wen(m0_wen),
        .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rvalid(m0_rvalid_w[0]), .m0_rdata(m0_rdata_w[0]),
        .m1_valid(m1_valid), .m1_ready(m1_ready_w[0]), .m1_addr(m1_addr), .m1_wen(m1_wen),
        .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rvalid(m1_rvalid_w[0]), .m1_rdata(m1_rdata_w[0]),
        .s_valid(s_valid_w[0]), .s_ready(s_ready), .s_addr(s_addr_w[0]), .s_wen(s_wen_w[0]),
        .s_wdata(s_wdata_w[0]), .s_wmask(s_wmask_w[0]), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .busy(busy_w[0]), .owner(owner_w[0])
    );

    membus_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready_w[1]), .m0_addr(m0_addr), .m0_wen(m0_wen),
        .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rvalid(m0_rvalid_w[1]), .m0_rdata(m0_rdata_w[1]),
        .m1_valid(m1_valid), .m1_ready(m1_ready_w[1]), .m1_addr(m1_addr), .m1_wen(m1_wen),
        .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rvalid(m1_rvalid_w[1]), .m1_rdata(m1_rdata_w[1]),
        .s_valid(s_valid_w[1]), .s_ready(s_ready), .s_addr(s_addr_w[1]), .s_wen(s_wen_w[1]),
        .s_wdata(s_wdata_w[1]), .s_wmask(s_wmask_w[1]), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .busy(busy_w[1]), .owner(owner_w[1])
    );

    // Clock: falling edge at 5, rising edges at 10, 20, ...
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard queues (bit k of an owner field belongs to instance k)
    logic [1:0]  grant_q [$];
    req_t        req_q0 [$];
    req_t        req_q1 [$];
    logic [65:0] rsp_q [$];

    // Transaction-level reference: one transaction in flight at most
    bit         free = 1'b1;
    int         phase = 0;          // 0 none, 1 presented downstream, 2 awaiting response
    int         cnt = 0;
    bit         last_rr = 1'b1;     // last round-robin winner was m1 after reset
    logic [1:0] own_m = 2'b00;
    int         rdy_dly_cfg = 0;
    int         rsp_dly_cfg = 0;
    bit         stray_en = 1'b0;
    bit         stray_once = 1'b0;
    bit         use_fix = 1'b0;
    logic [63:0] fix_rdata = 64'h0;

    // Per-cycle expectations read by the monitor
    bit         exp_busy = 1'b0;
    bit         exp_svalid = 1'b0;
    bit         exp_owner_chk = 1'b0;
    logic [1:0] exp_owner = 2'b00;

    task automatic chk1(input string nm, input int k, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0b expected %0b at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic chk64(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    task automatic set_m0(input logic v, input logic [31:0] a, input logic w,
                          input logic [63:0] d, input logic [7:0] m);
        m0_valid = v; m0_addr = a; m0_wen = w; m0_wdata = d; m0_wmask = m;
    endtask

    task automatic set_m1(input logic v, input logic [31:0] a, input logic w,
                          input logic [63:0] d, input logic [7:0] m);
        m1_valid = v; m1_addr = a; m1_wen = w; m1_wdata = d; m1_wmask = m;
    endtask

    // One clock cycle: play the downstream, predict this cycle, advance.
    task automatic tick();
        bit         was_free;
        logic [1:0] g;
        req_t       r0, r1;
        was_free      = free;
        exp_busy      = !was_free && !rst;
        exp_svalid    = (phase == 1) && !rst;
        exp_owner     = own_m;
        exp_owner_chk = !rst;
        s_ready       = 1'b0;
        s_rvalid      = 1'b0;
        s_rdata       = use_fix ? fix_rdata : {$urandom, $urandom};
        if (rst) begin
            free = 1'b1; phase = 0; cnt = 0; last_rr = 1'b1; own_m = 2'b00;
            grant_q.delete(); req_q0.delete(); req_q1.delete(); rsp_q.delete();
        end else begin
            if (phase == 2) begin
                if (cnt == 0) begin
                    s_rvalid = 1'b1;
                    rsp_q.push_back({own_m, s_rdata});
                    phase = 0;
                    free  = 1'b1;
                end else begin
                    cnt--;
                end
            end else begin
                if (phase == 1) begin
                    if (cnt == 0) begin
                        s_ready = 1'b1;
                        phase   = 2;
                        cnt     = pick(rsp_dly_cfg);
                    end else begin
                        cnt--;
                    end
                end
                // Responses nobody asked for must be dropped
                if ((stray_en && $urandom_range(0, 3) == 0) || stray_once) begin
                    s_rvalid = 1'b1;
                end
                stray_once = 1'b0;
            end
            if (was_free && (m0_valid || m1_valid)) begin
                g[0] = m1_valid && (!m0_valid || !last_rr);
                g[1] = !m0_valid;
                last_rr = g[0];
                r0 = {m0_addr, m0_wen, m0_wdata, m0_wmask};
                r1 = {m1_addr, m1_wen, m1_wdata, m1_wmask};
                grant_q.push_back(g);
                req_q0.push_back(g[0] ? r1 : r0);
                req_q1.push_back(g[1] ? r1 : r0);
                own_m = g;
                free  = 1'b0;
                phase = 1;
                cnt   = pick(rdy_dly_cfg);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 40 && !free; i++) tick();
    endtask

    // Monitor: compare both instances against the queue heads mid-cycle.
    always @(negedge clk) begin : mon
        logic [1:0]  g;
        logic [65:0] r;
        req_t        e;
        bit          gx, rx;
        gx = grant_q.size() > 0;
        g  = gx ? grant_q[0] : 2'b00;
        rx = rsp_q.size() > 0;
        r  = rx ? rsp_q[0] : 66'h0;
        for (int k = 0; k < 2; k++) begin
            chk1("m0_ready", k, m0_ready_w[k], gx && !g[k]);
            chk1("m1_ready", k, m1_ready_w[k], gx && g[k]);
            chk1("m0_rvalid", k, m0_rvalid_w[k], rx && !r[64 + k]);
            chk1("m1_rvalid", k, m1_rvalid_w[k], rx && r[64 + k]);
            chk64("m0_rdata", k, m0_rdata_w[k], s_rdata);
            chk64("m1_rdata", k, m1_rdata_w[k], s_rdata);
            if (rx) begin
                chk64("rsp_data", k, r[64 + k] ? m1_rdata_w[k] : m0_rdata_w[k], r[63:0]);
            end
            chk1("s_valid", k, s_valid_w[k], exp_svalid);
            chk1("busy", k, busy_w[k], exp_busy);
            if (exp_owner_chk) begin
                chk1("owner", k, owner_w[k], exp_owner[k]);
            end
            if (exp_svalid) begin
                if (k == 0) begin
                    e = (req_q0.size() > 0) ? req_q0[0] : '0;
                end else begin
                    e = (req_q1.size() > 0) ? req_q1[0] : '0;
                end
                chk64("s_addr", k, {32'h0, s_addr_w[k]}, {32'h0, e.addr});
                chk1("s_wen", k, s_wen_w[k], e.wen);
                chk64("s_wdata", k, s_wdata_w[k], e.wdata);
                chk64("s_wmask", k, {56'h0, s_wmask_w[k]}, {56'h0, e.wmask});
            end
        end
        if (gx) void'(grant_q.pop_front());
        if (rx) void'(rsp_q.pop_front());
        if (exp_svalid && s_ready) begin
            if (req_q0.size() > 0) void'(req_q0.pop_front());
            if (req_q1.size() > 0) void'(req_q1.pop_front());
        end
    end

    initial begin
        set_m0(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        set_m1(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = 64'h0;

        // Reset, with a requester already waiting
        rst = 1'b1;
        set_m0(1'b1, 32'h0000_0004, 1'b0, 64'h0, 8'hFF);
        tick(); tick();
        rst = 1'b0;
        set_m0(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        tick();

        // Single m0 read: ready 2 cycles into the issue, response 3 cycles later
        rdy_dly_cfg = 2; rsp_dly_cfg = 2;
        use_fix = 1'b1; fix_rdata = 64'h1122_3344_5566_7788;
        set_m0(1'b1, 32'h8000_0010, 1'b0, 64'h0, 8'hFF);
        tick();
        set_m0(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        idle_wait();
        use_fix = 1'b0;

        // Back-to-back with zero-wait downstream: one transaction per 3 cycles
        rdy_dly_cfg = 0; rsp_dly_cfg = 0;
        set_m0(1'b1, 32'h0000_1000, 1'b0, 64'h0, 8'hFF);
        repeat (9) tick();
        set_m0(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        idle_wait();

        // Contention: both held valid, then m0 drops and m1 stays
        rdy_dly_cfg = 1; rsp_dly_cfg = 1;
        set_m0(1'b1, 32'h1000_0000, 1'b1, 64'hA0A0_A0A0_A0A0_A0A0, 8'hFF);
        set_m1(1'b1, 32'h2000_0000, 1'b0, 64'h0B0B_0B0B_0B0B_0B0B, 8'h00);
        repeat (20) tick();
        set_m0(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        repeat (10) tick();
        set_m1(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        idle_wait();

        // m1 write whose inputs are cleared right after the grant
        rdy_dly_cfg = 3; rsp_dly_cfg = 1;
        set_m1(1'b1, 32'h8010_0000, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h0F);
        tick();
        set_m1(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        idle_wait();

        // Reset while awaiting a response, then a stray response
        rdy_dly_cfg = 0; rsp_dly_cfg = 6;
        set_m0(1'b1, 32'h3000_0000, 1'b0, 64'h0, 8'hFF);
        tick();
        set_m0(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        stray_once = 1'b1; tick();
        tick();
        rdy_dly_cfg = 1; rsp_dly_cfg = 1;
        set_m0(1'b1, 32'h3000_0040, 1'b0, 64'h0, 8'hFF);
        tick();
        set_m0(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        idle_wait();

        // Random traffic with random downstream delays, strays and resets
        rdy_dly_cfg = -1; rsp_dly_cfg = -1; stray_en = 1'b1;
        repeat (3000) begin
            set_m0(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, 8'($urandom));
            set_m1(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, 8'($urandom));
            rst = ($urandom_range(0, 149) == 0);
            tick();
            rst = 1'b0;
        end
        stray_en = 1'b0;
        set_m0(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        set_m1(1'b0, 32'h0, 1'b0, 64'h0, 8'h0);
        idle_wait();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 The block SHALL have parameter ROUND_ROBIN, default 1: 1 = round-robin between requesters, 0 = fixed priority with m0 highest.
REQ-002 The block SHALL have a single clock and a synchronous active-high reset, with ports as follows:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have requester 0 ports (CPU core), as follows:
- m0_valid in 1; m0_ready out 1; m0_addr in 32; m0_wen in 1; m0_wdata in 64; m0_wmask in 8.
- m0_rvalid out 1; m0_rdata out 64.
REQ-004 The block SHALL have requester 1 ports (draw/display engine), identical to m0 with the prefix m1_.
REQ-005 The block SHALL have downstream ports (to the membus->AXI adapter), as follows:
- s_valid out 1; s_ready in 1; s_addr out 32; s_wen out 1; s_wdata out 64; s_wmask out 8.
- s_rvalid in 1; s_rdata in 64.
REQ-006 The block SHALL have status ports, as follows:
- busy  out  1  state != IDLE.
- owner  out  1  requester of the current or last transaction.

Function
REQ-007 Membus handshake: a request transfers on valid&&ready in the same cycle; every accepted request, read or write, SHALL yield exactly one rvalid pulse.
REQ-008 At most one transaction SHALL be outstanding at any time.
REQ-009 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-010 IDLE: if any mN_valid is high, assert mN_ready for the granted requester only, in the same cycle; latch addr/wen/wdata/wmask into the request buffer; latch owner; next state ISSUE.
REQ-011 In IDLE, m0_ready and m1_ready SHALL never both be high; in ISSUE and WAIT both SHALL be low.
REQ-012 ISSUE: s_valid=1 and s_addr/s_wen/s_wdata/s_wmask SHALL come from the buffer, stable until s_ready; on s_ready the next state is WAIT.
REQ-013 WAIT: s_valid=0; on s_rvalid, assert rvalid for the owner in the same cycle, with rdata = s_rdata; next state is IDLE.
REQ-014 Latency: a request accepted in cycle N SHALL drive s_valid in cycle N+1; the response SHALL reach the requester in the same cycle as s_rvalid.
REQ-015 A new grant SHALL be possible in the cycle after the rvalid pulse, giving a minimum of 3 cycles per transaction.
REQ-016 mN_rdata SHALL equal s_rdata combinationally for both requesters.
REQ-017 mN_rvalid SHALL be s_rvalid gated by state==WAIT and owner==N.
REQ-018 Arbitration with a single requester valid: that requester is granted regardless of priority.
REQ-019 Arbitration with both requesters valid, ROUND_ROBIN=1: grant the requester other than last_grant; last_grant updates on every grant.
REQ-020 Arbitration with both requesters valid, ROUND_ROBIN=0: always grant m0.
REQ-021 s_rvalid outside WAIT, including stray responses after reset, SHALL be ignored and not forwarded.
REQ-022 s_rvalid coincident with s_ready in ISSUE SHALL be ignored; the downstream never responds in the acceptance cycle.
REQ-023 Requester inputs SHALL be sampled only in the IDLE grant cycle; later changes to them SHALL not affect the buffered request.

Reset
REQ-024 On rst, the next state SHALL be IDLE.
REQ-025 On rst, s_valid, m0_ready, m1_ready, m0_rvalid, m1_rvalid and busy SHALL be 0.
REQ-026 On rst, owner SHALL be 0, last_grant SHALL be 1 (so m0 wins the first contention), and the buffer SHALL be 0.
REQ-027 Reset asserted mid-transaction (ISSUE or WAIT) SHALL abandon the transaction with no rvalid issued; the rst-owned downstream adapter is reset concurrently.

Verification
REQ-028 Single read: m0 read addr 0x8000_0010, s_ready after 2 cycles, s_rvalid with 0x1122334455667788 three cycles later -> one m0_rvalid pulse with that data; m1_rvalid stays 0; busy is high from the grant+1 cycle to the rvalid cycle.
REQ-029 Contention with ROUND_ROBIN=1: m0 and m1 held valid continuously for 4 transactions -> grant order m0, m1, m0, m1; each response goes to the matching owner.
REQ-030 Contention with ROUND_ROBIN=0: both requesters held valid -> m0 granted on every transaction; m1 granted only after m0_valid drops.
REQ-031 Write buffering: m1 write addr 0x8010_0000, wdata 0xDEAD_BEEF_0000_0001, wmask 0x0F; m1 inputs changed to 0 the cycle after the grant -> s_* carry the original values until s_ready; s_wen=1.
REQ-032 Reset in WAIT, followed by a stray s_rvalid 2 cycles after reset -> no mN_rvalid pulse; the next m0 request is granted normally.
REQ-033 Back-to-back timing: s_ready and s_rvalid returned with zero wait -> grant in cycle 0, s_valid in cycle 1, rvalid in cycle 2, next grant in cycle 3.
